// File: rtl/cycle_sequencer.sv
// cycle_sequencer: instruction-cycle FSM in front of the combinational control decoder.
// Fetches an opcode and holds it on inst. Drives the decoder cycle bit (0/1). Opcodes with inst[7]
// set get a second, memory-backed cycle. Interrupts are taken only at fetch boundaries. Memory
// handshakes that stall are aborted after MEM_TIMEOUT cycles.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   inst_in[7:0]      opcode from instruction memory, valid with mem_ready in FETCH
//   mem_ready         fetch/data handshake complete
//   irq               level-sensitive interrupt request
//   j, lj, cli        jump-taken, long-jump class and interrupt-return from the decoder
//   inst[7:0]         latched opcode to the decoder
//   cycle             decoder cycle input (0 = first, 1 = second)
//   fetch_req         instruction fetch request
//   mem_req           data-memory request
//   pc_inc, pc_load   one-cycle PC increment / load pulses
//   pc_vec_sel        1 = PC loads pc_vec, 0 = PC loads datapath target
//   pc_vec[7:0]       constant IRQ_VEC
//   irq_ack           one-cycle interrupt acknowledge
//   int_en            registered interrupt enable
//   bus_err           one-cycle pulse on handshake timeout
module cycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [7:0]  IRQ_VEC     = 8'hF0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inst_in,
  input  logic       mem_ready,
  input  logic       irq,
  input  logic       j,
  input  logic       lj,
  input  logic       cli,
  output logic [7:0] inst,
  output logic       cycle,
  output logic       fetch_req,
  output logic       mem_req,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       pc_vec_sel,
  output logic [7:0] pc_vec,
  output logic       irq_ack,
  output logic       int_en,
  output logic       bus_err
);

  localparam int unsigned    CntW     = $clog2(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StRst,
    StFetch,
    StExec,
    StMem,
    StExec2,
    StIrq
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [7:0]      r_inst, w_inst_nxt;
  logic            r_int_en, w_int_en_nxt;
  logic [CntW-1:0] r_wait, w_wait_nxt;
  logic            w_limit;

  assign w_limit = (r_wait == CntLimit);
  assign inst    = r_inst;
  assign int_en  = r_int_en;
  assign pc_vec  = IRQ_VEC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StRst;
      r_inst   <= 8'h00;
      r_int_en <= 1'b0;
      r_wait   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_inst   <= w_inst_nxt;
      r_int_en <= w_int_en_nxt;
      r_wait   <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_inst_nxt   = r_inst;
    w_int_en_nxt = r_int_en;
    // Counter clears on any state change or handshake unless a wait branch below advances it.
    w_wait_nxt   = '0;
    cycle        = 1'b0;
    fetch_req    = 1'b0;
    mem_req      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    pc_vec_sel   = 1'b0;
    irq_ack      = 1'b0;
    bus_err      = 1'b0;

    unique case (r_state)
      StRst: begin
        w_state_nxt = StFetch;
      end

      StFetch: begin
        if (irq && r_int_en) begin
          w_state_nxt = StIrq;
        end else begin
          fetch_req = 1'b1;
          if (mem_ready) begin
            w_inst_nxt  = inst_in;
            pc_inc      = 1'b1;
            w_state_nxt = StExec;
          end else if (w_limit) begin
            // Retry the fetch from a fresh count; inst is left untouched.
            bus_err = 1'b1;
          end else begin
            w_wait_nxt = r_wait + CntW'(1);
          end
        end
      end

      StExec: begin
        if (r_inst[7]) begin
          mem_req     = 1'b1;
          w_state_nxt = StMem;
        end else begin
          if (lj) begin
            pc_load = 1'b1;
            if (cli) begin
              w_int_en_nxt = 1'b1;
            end
          end
          w_state_nxt = StFetch;
        end
      end

      StMem: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          w_state_nxt = StExec2;
        end else if (w_limit) begin
          // Abandon the op: EXEC2 and its pc_load are skipped.
          bus_err     = 1'b1;
          w_state_nxt = StFetch;
        end else begin
          w_wait_nxt = r_wait + CntW'(1);
        end
      end

      StExec2: begin
        cycle       = 1'b1;
        pc_load     = j;
        w_state_nxt = StFetch;
      end

      StIrq: begin
        irq_ack      = 1'b1;
        pc_load      = 1'b1;
        pc_vec_sel   = 1'b1;
        w_int_en_nxt = 1'b0;
        w_state_nxt  = StFetch;
      end

      default: begin
        w_state_nxt = StRst;
      end
    endcase
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: a per-cycle vector table for the main instruction flows,
// then hand-written sequences for fetch/data timeouts and asynchronous reset during MEM.
module tb_cycle_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] inst_in;
  logic       mem_ready;
  logic       irq;
  logic       j;
  logic       lj;
  logic       cli;
  logic [7:0] inst;
  logic       cycle;
  logic       fetch_req;
  logic       mem_req;
  logic       pc_inc;
  logic       pc_load;
  logic       pc_vec_sel;
  logic [7:0] pc_vec;
  logic       irq_ack;
  logic       int_en;
  logic       bus_err;

  cycle_sequencer #(
    .MEM_TIMEOUT(16),
    .IRQ_VEC    (8'hF0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_in   (inst_in),
    .mem_ready (mem_ready),
    .irq       (irq),
    .j         (j),
    .lj        (lj),
    .cli       (cli),
    .inst      (inst),
    .cycle     (cycle),
    .fetch_req (fetch_req),
    .mem_req   (mem_req),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .pc_vec_sel(pc_vec_sel),
    .pc_vec    (pc_vec),
    .irq_ack   (irq_ack),
    .int_en    (int_en),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {inst, cycle, fetch_req, mem_req, pc_inc, pc_load, pc_vec_sel, irq_ack, int_en, bus_err}
  logic [16:0] obs;
  assign obs = {inst, cycle, fetch_req, mem_req, pc_inc, pc_load, pc_vec_sel, irq_ack, int_en,
                bus_err};

  typedef struct {
    logic [7:0] inst_in;
    logic       rdy;
    logic       irq;
    logic       j;
    logic       lj;
    logic       cli;
    logic [7:0] e_inst;
    logic [8:0] e_flags;  // cyc freq mreq pcinc pcload vsel ack inten berr
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic [7:0] ii, input logic rdy, input logic ir, input logic jj,
                     input logic l, input logic c, input logic [7:0] ei, input logic [8:0] fl);
    vec_t v;
    v.inst_in = ii; v.rdy = rdy; v.irq = ir; v.j = jj; v.lj = l; v.cli = c;
    v.e_inst = ei; v.e_flags = fl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Inputs are already driven (posedge+1); sample mid-cycle, then advance to the next posedge+1.
  task automatic step(input string name, input logic [16:0] exp);
    @(negedge clk);
    check(name, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] ii, input logic rdy, input logic ir, input logic jj,
                        input logic l, input logic c);
    inst_in = ii; mem_ready = rdy; irq = ir; j = jj; lj = l; cli = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //    inst_in rdy irq j lj cli  e_inst  flags
    add(8'h00, 0, 0, 0, 0, 0, 8'h00, 9'b000000000);  // RST after release
    add(8'h41, 1, 0, 0, 0, 0, 8'h00, 9'b010100000);  // FETCH zero-wait
    add(8'h00, 0, 0, 0, 0, 0, 8'h41, 9'b000000000);  // EXEC short op
    add(8'h00, 0, 0, 0, 0, 0, 8'h41, 9'b010000000);  // FETCH wait
    add(8'hE0, 1, 0, 0, 0, 0, 8'h41, 9'b010100000);  // FETCH E0
    add(8'h00, 0, 0, 0, 0, 0, 8'hE0, 9'b001000000);  // EXEC long op
    add(8'h00, 0, 0, 0, 0, 0, 8'hE0, 9'b001000000);  // MEM wait 1
    add(8'h00, 0, 0, 0, 0, 0, 8'hE0, 9'b001000000);  // MEM wait 2
    add(8'h00, 1, 0, 0, 0, 0, 8'hE0, 9'b001000000);  // MEM ready
    add(8'h00, 0, 0, 1, 0, 0, 8'hE0, 9'b100010000);  // EXEC2 j=1
    add(8'h16, 1, 0, 0, 0, 0, 8'hE0, 9'b010100000);  // FETCH 16
    add(8'h00, 0, 1, 0, 1, 1, 8'h16, 9'b000010000);  // EXEC lj&cli, irq ignored
    add(8'h55, 1, 1, 0, 0, 0, 8'h16, 9'b000000010);  // FETCH irq taken, no fetch_req
    add(8'h00, 0, 1, 0, 0, 0, 8'h16, 9'b000011110);  // IRQ
    add(8'h02, 1, 1, 0, 0, 0, 8'h16, 9'b010100000);  // FETCH, int_en now 0
    add(8'h00, 0, 0, 0, 1, 0, 8'h02, 9'b000010000);  // EXEC lj without cli
    add(8'h03, 1, 0, 0, 0, 0, 8'h02, 9'b010100000);  // FETCH 03
    add(8'h00, 0, 0, 1, 0, 1, 8'h03, 9'b000000000);  // EXEC cli alone, j ignored
    add(8'h80, 1, 0, 0, 0, 0, 8'h03, 9'b010100000);  // FETCH 80
    add(8'h00, 0, 0, 0, 1, 1, 8'h80, 9'b001000000);  // EXEC long op ignores lj&cli
    add(8'h00, 1, 0, 0, 0, 0, 8'h80, 9'b001000000);  // MEM zero-wait
    add(8'h00, 0, 0, 0, 0, 0, 8'h80, 9'b100000000);  // EXEC2 j=0
    add(8'h00, 0, 1, 0, 0, 0, 8'h80, 9'b010000000);  // FETCH, irq masked

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (vecs[i]) begin
      set_in(vecs[i].inst_in, vecs[i].rdy, vecs[i].irq, vecs[i].j, vecs[i].lj, vecs[i].cli);
      step($sformatf("vec%0d", i), {vecs[i].e_inst, vecs[i].e_flags});
    end
    check("pc_vec", {9'h000, pc_vec}, {9'h000, 8'hF0});

    // Fetch timeout: bus_err every 16th cycle, then ready exactly on the limit cycle.
    do_reset();
    for (int k = 0; k < 48; k++) begin
      set_in(8'hAA, (k == 47), 1'b0, 1'b0, 1'b0, 1'b0);
      step($sformatf("fetch_to%0d", k),
           {8'h00, 1'b0, 1'b1, 1'b0, (k == 47), 1'b0, 1'b0, 1'b0, 1'b0,
            ((k % 16) == 15) && (k != 47)});
    end

    // Data timeout: abort to FETCH with no EXEC2 (j held high to expose a stray pc_load).
    set_in(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mto_exec", {8'hAA, 9'b001000000});
    for (int m = 0; m < 16; m++) begin
      step($sformatf("mto_mem%0d", m),
           {8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (m == 15)});
    end
    step("mto_fetch", {8'hAA, 9'b010000000});

    // Enable interrupts, start a long op, then reset asynchronously inside MEM.
    set_in(8'h16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ar_fetch1", {8'hAA, 9'b010100000});
    set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("ar_exec1", {8'h16, 9'b000010000});
    set_in(8'hC5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ar_fetch2", {8'h16, 9'b010100010});
    set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ar_exec2", {8'hC5, 9'b001000010});
    step("ar_mem", {8'hC5, 9'b001000010});
    #2 rst_n = 1'b0;
    #1 check("ar_async", obs, 17'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("ar_rst", 17'h0);
    step("ar_fetch", {8'h00, 9'b010000000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
